// File: rtl/im_loader.sv
// Instruction-memory loader: streams DEPTH words into memory through a registered write port.
// Optional running checksum of written words when IM_LOADER_CHECKSUM_EN is defined.
module im_loader #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memData,
    output logic        busy,
    output logic        done,
    output logic [4:0]  count,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [4:0]  index_q, index_d;
    logic [4:0]  count_q, count_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        accept, launch, final_beat;

    assign accept     = in_valid && (state_q == LOAD);
    assign launch     = start && ((state_q == IDLE) || (state_q == DONE));
    assign final_beat = accept && (in_last || (index_q == LAST_IDX));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (final_beat) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = (state_q == LOAD) || (state_q == FLUSH);
        done     = (state_q == DONE);
    end

    // Write port is a one-cycle-delayed copy of the accepted beat.
    always_comb begin
        index_d = index_q;
        count_d = count_q;
        wr_d    = accept;
        addr_d  = addr_q;
        data_d  = data_q;
        if (launch) begin
            index_d = '0;
            count_d = '0;
        end else if (accept) begin
            index_d = index_q + 5'd1;
            count_d = count_q + 5'd1;
            addr_d  = BASE_ADDR + {25'd0, index_q, 2'b00};
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= '0;
            count_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            index_q <= index_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign memWrite = wr_q;
    assign memAddr  = addr_q;
    assign memData  = data_q;
    assign count    = count_q;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset || launch) csum_q <= '0;
        else if (accept)     csum_q <= csum_q + in_data;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Randomized and directed bench for im_loader, checked every cycle against a behavioural model.
module tb_im_loader;

    localparam int unsigned DEPTH     = 16;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, memWrite, busy, done;
    logic [31:0] memAddr, memData, checksum;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    im_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .memWrite(memWrite), .memAddr(memAddr), .memData(memData),
        .busy(busy), .done(done), .count(count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: session phase plus words taken so far.
    int          m_phase = 0;  // 0 idle, 1 loading, 2 last write pending, 3 finished
    int          m_words = 0;
    logic        m_wr = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0, m_sum = '0;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_words = 0; m_wr = 1'b0;
            m_addr = '0; m_data = '0; m_sum = '0;
            model_ok = 1'b1;
        end else begin
            m_wr = 1'b0;
            if (m_phase == 1 && in_valid) begin
                m_wr   = 1'b1;
                m_addr = BASE_ADDR + 32'(m_words) * 32'd4;
                m_data = in_data;
                m_sum  = m_sum + in_data;
                m_words++;
                if (in_last || m_words == DEPTH) m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 3;
            end else if ((m_phase == 0 || m_phase == 3) && start) begin
                m_phase = 1; m_words = 0; m_sum = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok && !reset) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
            chk("done", 32'(done), 32'(m_phase == 3));
            chk("memWrite", 32'(memWrite), 32'(m_wr));
            chk("memAddr", memAddr, m_addr);
            chk("memData", memData, m_data);
            chk("count", 32'(count), 32'(m_words));
`ifdef IM_LOADER_CHECKSUM_EN
            chk("checksum", checksum, m_sum);
`else
            chk("checksum", checksum, 32'h0);
`endif
        end
    end

    // Write log and longest run of consecutive write cycles.
    logic [31:0] wr_addrs[$];
    int          run = 0, max_run = 0;
    always @(negedge clk) begin
        if (memWrite) begin
            wr_addrs.push_back(memAddr);
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic clear_log();
        wr_addrs.delete();
        max_run = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        logic r;
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) return;
        end
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin #2; return; end
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;

        // Full back-to-back load.
        clear_log();
        pulse_start();
        for (int i = 0; i < 16; i++) send(32'h1000_0000 + 32'(i), 1'b0);
        idle_inputs();
        wait_done();
        chk("full_count", 32'(count), 32'd16);
        chk("full_writes", 32'(wr_addrs.size()), 32'd16);
        chk("full_run", 32'(max_run), 32'd16);
        chk("full_first_addr", wr_addrs[0], 32'h0000_0000);
        chk("full_last_addr", wr_addrs[15], 32'h0000_003C);

        // Early termination with in_last.
        clear_log();
        pulse_start();
        send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b1);
        idle_inputs();
        @(negedge clk);
        chk("last_ready_low", 32'(in_ready), 32'd0);
        wait_done();
        chk("last_count", 32'(count), 32'd3);
        chk("last_writes", 32'(wr_addrs.size()), 32'd3);
        chk("last_addr2", wr_addrs[2], 32'h0000_0008);
        chk("last_done", 32'(done), 32'd1);

        // Gapped beats.
        clear_log();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send(32'h2000_0000 + 32'(i), i == 5);
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        idle_inputs();
        wait_done();
        chk("gap_writes", 32'(wr_addrs.size()), 32'd6);
        chk("gap_addr5", wr_addrs[5], 32'h0000_0014);

        // Reset right after beat 5, with a sixth beat offered on the same edge.
        pulse_start();
        for (int i = 0; i < 5; i++) send(32'h3000_0000 + 32'(i), 1'b0);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; idle_inputs();
        @(negedge clk);
        chk("abort_nowrite", 32'(memWrite), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        clear_log();
        pulse_start();
        for (int i = 0; i < 16; i++) send(32'h4000_0000 + 32'(i), 1'b0);
        idle_inputs();
        wait_done();
        chk("reload_count", 32'(count), 32'd16);
        chk("reload_writes", 32'(wr_addrs.size()), 32'd16);

        // Checksum wraparound.
        pulse_start();
        send(32'hFFFF_FFFF, 1'b0); send(32'h0000_0002, 1'b1);
        idle_inputs();
        wait_done();
`ifdef IM_LOADER_CHECKSUM_EN
        chk("csum_wrap", checksum, 32'h0000_0001);
`else
        chk("csum_off", checksum, 32'h0000_0000);
`endif

        // start ignored during LOAD, in_valid ignored in DONE, restart from DONE.
        pulse_start();
        send(32'h5, 1'b0);
        in_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send(32'h6, 1'b1);
        idle_inputs();
        wait_done();
        chk("nostart_count", 32'(count), 32'd2);
        clear_log();
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_ignores_valid", 32'(wr_addrs.size()), 32'd0);
        chk("done_hold", 32'(done), 32'd1);
        in_valid = 1'b0;
        pulse_start();
        send(32'h7, 1'b1);
        idle_inputs();
        wait_done();
        chk("restart_addr", wr_addrs[0], BASE_ADDR);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 1) == 1);
            in_last  = ($urandom_range(0, 9) == 0);
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        reset = 1'b0; idle_inputs();
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
